i2c_target_regs: RTL and testbench

//  I2C target (slave) with an internal byte-register bank, the bus-side counterpart of our Wishbone-driven I2C master.
//  It lets on-board or loop-back tests exercise the master, and it gives the fabric a register window reachable over I2C.
//  It oversamples SCL/SDA on the system clock, detects START/STOP, decodes the 7-bit address and drives SDA open-drain.
//  It never stretches SCL.

---
 rtl/i2c_pkg.sv | 21 ++
 rtl/i2c_bus_cond.sv | 42 ++++
 rtl/i2c_target_regs.sv | 174 +++++++++++++++++
 tb/tb_i2c_target_regs.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the target register bank and the Wishbone-driven master.
// Holds the protocol-state encoding, ACK/NACK levels and the R/W bit position.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_WAIT_STOP
   } i2c_state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
   localparam int   RW_BIT   = 0;
   localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_bus_cond.sv
// SCL/SDA conditioning: 2-FF synchroniser, previous-sample register, SCL edge and
// START/STOP detection. Registers reset high so a released bus yields no events.
module i2c_bus_cond (
   input  logic clk,
   input  logic reset,
   input  logic scl,
   input  logic sda,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic scl_p0, scl_p1, scl_p2;
   logic sda_p0, sda_p1, sda_p2;

   always_ff @(posedge clk) begin
      if (reset) begin
         scl_p0 <= 1'b1;
         scl_p1 <= 1'b1;
         scl_p2 <= 1'b1;
         sda_p0 <= 1'b1;
         sda_p1 <= 1'b1;
         sda_p2 <= 1'b1;
      end else begin
         scl_p0 <= scl;
         scl_p1 <= scl_p0;
         scl_p2 <= scl_p1;
         sda_p0 <= sda;
         sda_p1 <= sda_p0;
         sda_p2 <= sda_p1;
      end
   end

   assign sda_s     = sda_p1;
   assign scl_rise  = scl_p1 & ~scl_p2;
   assign scl_fall  = ~scl_p1 & scl_p2;
   assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
   assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-register bank to the bus and to the local fabric.
// Oversamples SCL/SDA on clk, never stretches SCL, drives SDA open-drain.
module i2c_target_regs
   import i2c_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = 7'h42,
   parameter int         NREGS    = 16,
   localparam int        PW       = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i2c_scl,
   inout  wire           i2c_sda,
   input  logic [PW-1:0] loc_addr,
   input  logic          loc_we,
   input  logic [7:0]    loc_wdata,
   output logic [7:0]    loc_rdata,
   output logic          wr_stb,
   output logic [PW-1:0] wr_addr,
   output logic [7:0]    wr_data,
   output logic          busy
);

   i2c_state_t    state, state_nxt;
   logic [7:0]    bank [NREGS];
   logic [7:0]    shift;
   logic [3:0]    bit_cnt;
   logic [PW-1:0] ptr;
   logic          sda_oe, ack_ph, first, rw;
   logic          sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic          byte_done, rd_load;
   logic [7:0]    byte_nxt, rd_byte;

   i2c_bus_cond u_cond (
      .clk       (clk),
      .reset     (reset),
      .scl       (i2c_scl),
      .sda       (i2c_sda),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;
   assign byte_nxt  = {shift[6:0], sda_s};
   assign byte_done = scl_rise && (bit_cnt == 4'd7);
   assign rd_byte   = bank[ptr];
   assign busy      = state inside {ST_ADDR_ACK, ST_WR_DATA, ST_WR_ACK, ST_RD_DATA, ST_RD_ACK};

   always_comb begin
      state_nxt = state;
      rd_load   = 1'b0;
      if (start_det) begin
         state_nxt = ST_ADDR;
      end else if (stop_det) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_ADDR:
               if (byte_done)
                  state_nxt = (byte_nxt[7:1] == I2C_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
            ST_ADDR_ACK:
               if (scl_fall && ack_ph) begin
                  state_nxt = (rw == RW_READ) ? ST_RD_DATA : ST_WR_DATA;
                  rd_load   = (rw == RW_READ);
               end
            ST_WR_DATA:
               if (byte_done) state_nxt = ST_WR_ACK;
            ST_WR_ACK:
               if (scl_fall && ack_ph) state_nxt = ST_WR_DATA;
            ST_RD_DATA:
               if (scl_fall && (bit_cnt == 4'd8)) state_nxt = ST_RD_ACK;
            ST_RD_ACK:
               if (scl_rise && (sda_s == I2C_NACK)) begin
                  state_nxt = ST_WAIT_STOP;
               end else if (scl_fall && ack_ph) begin
                  state_nxt = ST_RD_DATA;
                  rd_load   = 1'b1;
               end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      wr_stb <= 1'b0;
      if (reset) begin
         state     <= ST_IDLE;
         sda_oe    <= 1'b0;
         ptr       <= '0;
         bit_cnt   <= '0;
         ack_ph    <= 1'b0;
         first     <= 1'b0;
         rw        <= 1'b0;
         loc_rdata <= 8'h00;
         wr_addr   <= '0;
         wr_data   <= 8'h00;
         for (int i = 0; i < NREGS; i++) bank[i] <= 8'h00;
      end else begin
         state     <= state_nxt;
         loc_rdata <= bank[loc_addr];
         // Local write first so a same-index I2C write below overrides it.
         if (loc_we) bank[loc_addr] <= loc_wdata;
         if (start_det) begin
            bit_cnt <= '0;
            sda_oe  <= 1'b0;
            ack_ph  <= 1'b0;
         end else if (stop_det) begin
            sda_oe  <= 1'b0;
            ack_ph  <= 1'b0;
         end else begin
            case (state)
               ST_ADDR:
                  if (scl_rise) begin
                     shift   <= byte_nxt;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (byte_done) rw <= byte_nxt[RW_BIT];
                  end
               ST_ADDR_ACK, ST_WR_ACK:
                  if (scl_fall) begin
                     sda_oe  <= ~ack_ph;
                     ack_ph  <= ~ack_ph;
                     if (ack_ph) bit_cnt <= '0;
                     if (ack_ph && state == ST_ADDR_ACK) first <= 1'b1;
                  end
               ST_WR_DATA:
                  if (scl_rise) begin
                     shift   <= byte_nxt;
                     bit_cnt <= bit_cnt + 4'd1;
                     if (byte_done) begin
                        bit_cnt <= '0;
                        if (first) begin
                           ptr   <= byte_nxt[PW-1:0];
                           first <= 1'b0;
                        end else begin
                           bank[ptr] <= byte_nxt;
                           wr_stb    <= 1'b1;
                           wr_addr   <= ptr;
                           wr_data   <= byte_nxt;
                           ptr       <= ptr + PW'(1);
                        end
                     end
                  end
               ST_RD_DATA:
                  if (scl_fall) begin
                     if (bit_cnt == 4'd8) begin
                        sda_oe <= 1'b0;
                        ack_ph <= 1'b0;
                     end else begin
                        sda_oe  <= ~shift[7];
                        shift   <= {shift[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                     end
                  end
               ST_RD_ACK: begin
                  if (scl_rise) ack_ph <= (sda_s == I2C_ACK);
                  if (scl_fall && ack_ph) ack_ph <= 1'b0;
               end
               default: sda_oe <= 1'b0;
            endcase
            // The MSB goes out on the same fall that ends the ACK slot.
            if (rd_load) begin
               sda_oe  <= ~rd_byte[7];
               shift   <= {rd_byte[6:0], 1'b0};
               ptr     <= ptr + PW'(1);
               bit_cnt <= 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master with a pulled-up SDA,
// plus monitors for wr_stb, target SDA drive and busy.
module tb_i2c_target_regs;

   localparam int Q = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       scl = 1'b1;
   logic       sda_drv = 1'b0;
   wire        i2c_sda;
   logic [3:0] loc_addr = 4'h0;
   logic       loc_we = 1'b0;
   logic [7:0] loc_wdata = 8'h00;
   logic [7:0] loc_rdata, wr_data;
   logic [3:0] wr_addr;
   logic       wr_stb, busy;

   int n_assert = 0;
   int n_fail = 0;
   int stb_n = 0;
   int drv_n = 0;
   int busy_n = 0;
   logic [3:0] log_addr [16];
   logic [7:0] log_data [16];

   assign i2c_sda = sda_drv ? 1'b0 : 1'bz;
   pullup (i2c_sda);

   always #5 clk = ~clk;

   i2c_target_regs #(.I2C_ADDR(7'h42), .NREGS(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .i2c_scl   (scl),
      .i2c_sda   (i2c_sda),
      .loc_addr  (loc_addr),
      .loc_we    (loc_we),
      .loc_wdata (loc_wdata),
      .loc_rdata (loc_rdata),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always begin
      @(posedge clk);
      #2;
      if (wr_stb === 1'b1) begin
         if (stb_n < 16) begin
            log_addr[stb_n] = wr_addr;
            log_data[stb_n] = wr_data;
         end
         stb_n++;
      end
      if (!sda_drv && i2c_sda === 1'b0) drv_n++;
      if (busy === 1'b1) busy_n++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: observed timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      clk_wait(Q); sda_drv = 1'b0;
      clk_wait(Q); scl = 1'b1;
      clk_wait(Q); sda_drv = 1'b1;
      clk_wait(Q); scl = 1'b0;
   endtask

   task automatic i2c_stop();
      clk_wait(Q); sda_drv = 1'b1;
      clk_wait(Q); scl = 1'b1;
      clk_wait(Q); sda_drv = 1'b0;
      clk_wait(Q);
   endtask

   // col pulses loc_we so it is sampled in the clk that commits the 8th bit.
   task automatic send_bit(input logic b, input bit col);
      clk_wait(Q); sda_drv = ~b;
      clk_wait(Q); scl = 1'b1;
      if (col) begin
         clk_wait(2); loc_we = 1'b1;
         clk_wait(1); loc_we = 1'b0;
         clk_wait(2*Q-3);
      end else begin
         clk_wait(2*Q);
      end
      scl = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit col, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(b[i], col && i == 0);
      clk_wait(Q); sda_drv = 1'b0;
      clk_wait(Q); scl = 1'b1;
      clk_wait(Q); ack = i2c_sda;
      clk_wait(Q); scl = 1'b0;
   endtask

   task automatic read_bit(output logic b);
      clk_wait(Q); sda_drv = 1'b0;
      clk_wait(Q); scl = 1'b1;
      clk_wait(Q); b = i2c_sda;
      clk_wait(Q); scl = 1'b0;
   endtask

   task automatic read_byte(input logic m_ack, output logic [7:0] d);
      for (int i = 7; i >= 0; i--) read_bit(d[i]);
      clk_wait(Q); sda_drv = m_ack;
      clk_wait(Q); scl = 1'b1;
      clk_wait(2*Q); scl = 1'b0;
   endtask

   task automatic loc_wr(input logic [3:0] a, input logic [7:0] d);
      @(negedge clk);
      loc_addr = a; loc_wdata = d; loc_we = 1'b1;
      @(negedge clk);
      loc_we = 1'b0;
   endtask

   task automatic loc_rd(input logic [3:0] a, output logic [7:0] d);
      @(negedge clk);
      loc_addr = a;
      @(posedge clk);
      #1 d = loc_rdata;
   endtask

   initial begin
      logic       ack;
      logic [7:0] d;
      logic [3:0] nib;
      int         stb_before;

      clk_wait(4);
      reset = 1'b0;
      clk_wait(2);
      check("rst_busy", busy, 1'b0);
      check("rst_wr_stb", wr_stb, 1'b0);
      check("rst_wr_addr", wr_addr, 4'h0);
      check("rst_wr_data", wr_data, 8'h00);
      check("rst_loc_rdata", loc_rdata, 8'h00);
      check("rst_sda", i2c_sda, 1'b1);

      // Write burst starting at register 3
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t1_ack_addr", ack, 1'b0);
      check("t1_busy", busy, 1'b1);
      send_byte(8'h03, 1'b0, ack); check("t1_ack_ptr", ack, 1'b0);
      send_byte(8'hA5, 1'b0, ack); check("t1_ack_d0", ack, 1'b0);
      send_byte(8'h5A, 1'b0, ack); check("t1_ack_d1", ack, 1'b0);
      i2c_stop();
      clk_wait(2);
      check("t1_busy_stop", busy, 1'b0);
      check("t1_stb_count", 16'(stb_n), 16'd2);
      check("t1_stb0_addr", log_addr[0], 4'h3);
      check("t1_stb0_data", log_data[0], 8'hA5);
      check("t1_stb1_addr", log_addr[1], 4'h4);
      check("t1_stb1_data", log_data[1], 8'h5A);
      loc_rd(4'h4, d); check("t1_loc_rd4", d, 8'h5A);

      // Read with repeated START, pointer wrapping F -> 0
      loc_wr(4'hF, 8'hC3);
      loc_wr(4'h0, 8'h7E);
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t2_ack_waddr", ack, 1'b0);
      send_byte(8'h0F, 1'b0, ack); check("t2_ack_ptr", ack, 1'b0);
      i2c_start();
      send_byte(8'h85, 1'b0, ack); check("t2_ack_raddr", ack, 1'b0);
      read_byte(1'b1, d); check("t2_rd_f", d, 8'hC3);
      read_byte(1'b0, d); check("t2_rd_0", d, 8'h7E);
      i2c_stop();
      clk_wait(2);
      check("t2_busy_stop", busy, 1'b0);

      // Address miss
      drv_n = 0; busy_n = 0; stb_before = stb_n;
      i2c_start();
      send_byte(8'h90, 1'b0, ack); check("t3_nack_addr", ack, 1'b1);
      send_byte(8'h11, 1'b0, ack); check("t3_nack_data", ack, 1'b1);
      i2c_stop();
      clk_wait(2);
      check("t3_sda_driven", 16'(drv_n), 16'd0);
      check("t3_busy_seen", 16'(busy_n), 16'd0);
      check("t3_stb_count", 16'(stb_n), 16'(stb_before));

      // Same-clk collision on register 2
      loc_addr = 4'h2; loc_wdata = 8'h11;
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t4_ack_addr", ack, 1'b0);
      send_byte(8'h02, 1'b0, ack); check("t4_ack_ptr", ack, 1'b0);
      send_byte(8'hE7, 1'b1, ack); check("t4_ack_data", ack, 1'b0);
      i2c_stop();
      clk_wait(2);
      check("t4_stb_count", 16'(stb_n), 16'd3);
      check("t4_stb_addr", log_addr[2], 4'h2);
      check("t4_stb_data", log_data[2], 8'hE7);
      loc_rd(4'h2, d); check("t4_bank2", d, 8'hE7);

      // Reset during bit 5 of a read of bank[3]=A5
      i2c_start();
      send_byte(8'h85, 1'b0, ack); check("t5_ack_addr", ack, 1'b0);
      for (int i = 3; i >= 0; i--) read_bit(nib[i]);
      check("t5_first_nibble", nib, 4'hA);
      clk_wait(Q);
      check("t5_sda_driven", i2c_sda, 1'b0);
      reset = 1'b1;
      @(posedge clk);
      #1 check("t5_sda_released", i2c_sda, 1'b1);
      check("t5_busy_reset", busy, 1'b0);
      clk_wait(1);
      reset = 1'b0;
      i2c_start();
      send_byte(8'h85, 1'b0, ack); check("t5_ack_readdr", ack, 1'b0);
      read_byte(1'b0, d); check("t5_rd_bank0", d, 8'h00);
      i2c_stop();

      // STOP in the middle of a data byte
      stb_before = stb_n;
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t6_ack_addr", ack, 1'b0);
      send_byte(8'h05, 1'b0, ack); check("t6_ack_ptr", ack, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
      i2c_stop();
      clk_wait(2);
      check("t6_busy", busy, 1'b0);
      check("t6_no_stb", 16'(stb_n), 16'(stb_before));
      loc_rd(4'h5, d); check("t6_bank5", d, 8'h00);
      i2c_start();
      send_byte(8'h84, 1'b0, ack); check("t6_ack_addr2", ack, 1'b0);
      send_byte(8'h07, 1'b0, ack);
      send_byte(8'h3C, 1'b0, ack); check("t6_ack_data2", ack, 1'b0);
      i2c_stop();
      clk_wait(2);
      check("t6_stb_count2", 16'(stb_n), 16'(stb_before + 1));
      check("t6_stb_addr2", log_addr[3], 4'h7);
      check("t6_stb_data2", log_data[3], 8'h3C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
